// File: rtl/game_master_fsm_multi_target.sv
// Round controller for the multi-target torpedo game.
// Positions sprites, arms shots from a limited magazine, tracks per-target hits,
// keeps a saturating score and declares win/loss. Every output is registered from
// the next-state decode, so it is valid in the first cycle of the state it belongs to.
//
//   state     | meaning
//   ST_START  | load target/torpedo start positions, refill magazine, clear hits
//   ST_AIM    | targets moving, waiting for a fire-button rising edge
//   ST_SHOOT  | torpedo in flight, waiting for a hit, a miss or a lost target
//   ST_RELOAD | torpedo repositioned; decide win, loss or next shot
//   ST_END    | round over; end-of-game timer holds us here
module game_master_fsm_multi_target #(
  parameter int N_TARGETS = 2,
  parameter int N_SHOTS   = 3,
  parameter int SCORE_W   = 8,
  localparam int SHOT_W   = $clog2(N_SHOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 key,
  output logic [N_TARGETS-1:0] sprite_target_write_xy,
  output logic [N_TARGETS-1:0] sprite_target_write_dxy,
  output logic [N_TARGETS-1:0] sprite_target_enable_update,
  output logic                 sprite_torpedo_write_xy,
  output logic                 sprite_torpedo_write_dxy,
  output logic                 sprite_torpedo_enable_update,
  input  logic [N_TARGETS-1:0] sprite_target_within_screen,
  input  logic                 sprite_torpedo_within_screen,
  input  logic [N_TARGETS-1:0] collision,
  output logic                 end_of_game_timer_start,
  input  logic                 end_of_game_timer_running,
  output logic                 game_won,
  output logic [SCORE_W-1:0]   score,
  output logic [SHOT_W-1:0]    shots_left
);

  typedef enum logic [2:0] {
    ST_START  = 3'd0,
    ST_AIM    = 3'd1,
    ST_SHOOT  = 3'd2,
    ST_RELOAD = 3'd3,
    ST_END    = 3'd4
  } state_t;

  state_t               state;
  logic [N_TARGETS-1:0] hit;
  logic [N_TARGETS-1:0] alive;
  logic [N_TARGETS-1:0] hits;
  logic                 key_q;
  logic                 fire;
  logic                 lost;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_next;

  // Hit/miss/fire qualifiers; dead targets are masked out of collision and screen checks
  always_comb begin
    alive      = ~hit;
    hits       = collision & alive;
    lost       = |(alive & ~sprite_target_within_screen);
    fire       = key & ~key_q & (shots_left != '0);
    score_sum  = {1'b0, score} + (SCORE_W + 1)'($countones(hits));
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // Round FSM with outputs registered from the next-state decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                        <= ST_START;
      hit                          <= '0;
      key_q                        <= 1'b0;
      score                        <= '0;
      shots_left                   <= '0;
      game_won                     <= 1'b0;
      sprite_target_write_xy       <= '0;
      sprite_target_write_dxy      <= '0;
      sprite_target_enable_update  <= '0;
      sprite_torpedo_write_xy      <= 1'b0;
      sprite_torpedo_write_dxy     <= 1'b0;
      sprite_torpedo_enable_update <= 1'b0;
      end_of_game_timer_start      <= 1'b0;
    end else begin
      key_q                        <= key;
      sprite_target_write_xy       <= '0;
      sprite_target_write_dxy      <= '0;
      sprite_target_enable_update  <= '0;
      sprite_torpedo_write_xy      <= 1'b0;
      sprite_torpedo_write_dxy     <= 1'b0;
      sprite_torpedo_enable_update <= 1'b0;
      end_of_game_timer_start      <= 1'b0;
      case (state)
        ST_START: begin
          // Out of reset the START outputs have not been shown yet (torpedo_write_xy
          // is still low), so re-enter START once to present them for one cycle.
          if (!sprite_torpedo_write_xy) begin
            state                   <= ST_START;
            sprite_target_write_xy  <= '1;
            sprite_target_write_dxy <= '1;
            sprite_torpedo_write_xy <= 1'b1;
            hit                     <= '0;
            shots_left              <= SHOT_W'(N_SHOTS);
            game_won                <= 1'b0;
          end else begin
            state                       <= ST_AIM;
            sprite_target_enable_update <= alive;
          end
        end
        ST_AIM: begin
          if (lost) begin
            state                   <= ST_END;
            end_of_game_timer_start <= 1'b1;
          end else if (fire) begin
            state                        <= ST_SHOOT;
            shots_left                   <= shots_left - SHOT_W'(1);
            sprite_torpedo_write_dxy     <= 1'b1;
            sprite_torpedo_enable_update <= 1'b1;
            sprite_target_enable_update  <= alive;
          end else begin
            sprite_target_enable_update <= alive;
          end
        end
        ST_SHOOT: begin
          if (hits != '0) begin
            state                       <= ST_RELOAD;
            hit                         <= hit | hits;
            score                       <= score_next;
            sprite_torpedo_write_xy     <= 1'b1;
            sprite_target_enable_update <= alive & ~hits;
          end else if (lost) begin
            state                   <= ST_END;
            end_of_game_timer_start <= 1'b1;
          end else if (!sprite_torpedo_within_screen) begin
            state                       <= ST_RELOAD;
            sprite_torpedo_write_xy     <= 1'b1;
            sprite_target_enable_update <= alive;
          end else begin
            sprite_torpedo_enable_update <= 1'b1;
            sprite_target_enable_update  <= alive;
          end
        end
        ST_RELOAD: begin
          if (&hit) begin
            state                   <= ST_END;
            game_won                <= 1'b1;
            end_of_game_timer_start <= 1'b1;
          end else if (shots_left == '0) begin
            state                   <= ST_END;
            end_of_game_timer_start <= 1'b1;
          end else begin
            state                       <= ST_AIM;
            sprite_target_enable_update <= alive;
          end
        end
        ST_END: begin
          // The start pulse marks the entry cycle, where the running flag is not yet valid
          if (end_of_game_timer_start || end_of_game_timer_running) begin
            state <= ST_END;
          end else begin
            state                   <= ST_START;
            sprite_target_write_xy  <= '1;
            sprite_target_write_dxy <= '1;
            sprite_torpedo_write_xy <= 1'b1;
            hit                     <= '0;
            shots_left              <= SHOT_W'(N_SHOTS);
            game_won                <= 1'b0;
          end
        end
        default: begin
          state                   <= ST_START;
          sprite_target_write_xy  <= '1;
          sprite_target_write_dxy <= '1;
          sprite_torpedo_write_xy <= 1'b1;
          hit                     <= '0;
          shots_left              <= SHOT_W'(N_SHOTS);
          game_won                <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_master_fsm_multi_target.sv
// Bench for game_master_fsm_multi_target: a table of directed vectors from reset,
// hand-written multi-cycle corner cases and a long random run, all checked against
// a round-level reference model.
module tb_game_master_fsm_multi_target;
  localparam int NT = 2;
  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key = 1'b0;
  logic [1:0] tws = 2'b11;
  logic       pws = 1'b1;
  logic [1:0] col = 2'b00;
  logic       run = 1'b0;

  logic [1:0] txy, tdxy, ten;
  logic       pxy, pdxy, pen, ts, won;
  logic [7:0] score;
  logic [1:0] shots;

  game_master_fsm_multi_target #(.N_TARGETS(NT), .N_SHOTS(NS), .SCORE_W(8)) dut (
    .clk                          (clk),
    .reset                        (reset),
    .key                          (key),
    .sprite_target_write_xy       (txy),
    .sprite_target_write_dxy      (tdxy),
    .sprite_target_enable_update  (ten),
    .sprite_torpedo_write_xy      (pxy),
    .sprite_torpedo_write_dxy     (pdxy),
    .sprite_torpedo_enable_update (pen),
    .sprite_target_within_screen  (tws),
    .sprite_torpedo_within_screen (pws),
    .collision                    (col),
    .end_of_game_timer_start      (ts),
    .end_of_game_timer_running    (run),
    .game_won                     (won),
    .score                        (score),
    .shots_left                   (shots)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: round phase as a name, plus magazine, hits, score and result
  string      m_ph;
  bit         m_shown;
  int         m_end_age;
  int         m_shots;
  int         m_score;
  logic [1:0] m_hit;
  logic       m_won;
  logic       m_keyq;
  logic [1:0] e_txy, e_tdxy, e_ten;
  logic       e_pxy, e_pdxy, e_pen, e_ts;

  task automatic m_reset();
    m_ph = "start"; m_shown = 0; m_end_age = 0; m_shots = 0; m_score = 0;
    m_hit = 2'b00; m_won = 1'b0; m_keyq = 1'b0;
    e_txy = 2'b00; e_tdxy = 2'b00; e_ten = 2'b00;
    e_pxy = 1'b0; e_pdxy = 1'b0; e_pen = 1'b0; e_ts = 1'b0;
  endtask

  task automatic m_step();
    logic [1:0] alive, h;
    bit         lost, pressed, entered;
    string      nph;
    alive   = ~m_hit;
    lost    = |(alive & ~tws);
    pressed = key && !m_keyq && (m_shots != 0);
    m_keyq  = key;
    nph     = m_ph;
    if (m_ph == "start") begin
      nph = m_shown ? "aim" : "start";
    end else if (m_ph == "aim") begin
      if (lost) nph = "end";
      else if (pressed) begin nph = "shoot"; m_shots = m_shots - 1; end
    end else if (m_ph == "shoot") begin
      h = col & alive;
      if (h != 2'b00) begin
        m_hit   = m_hit | h;
        m_score = m_score + $countones(h);
        if (m_score > 255) m_score = 255;
        nph = "reload";
      end else if (lost) nph = "end";
      else if (!pws) nph = "reload";
    end else if (m_ph == "reload") begin
      if (m_hit == 2'b11) begin m_won = 1'b1; nph = "end"; end
      else if (m_shots == 0) nph = "end";
      else nph = "aim";
    end else begin
      if (m_end_age != 0 && !run) nph = "start";
    end
    entered = (nph != m_ph) || (nph == "start" && !m_shown);
    if (nph == "start" && entered) begin
      m_hit = 2'b00; m_shots = NS; m_won = 1'b0; m_shown = 1;
    end
    m_end_age = (nph == "end" && entered) ? 0 : m_end_age + 1;
    e_txy = 2'b00; e_tdxy = 2'b00; e_ten = 2'b00;
    e_pxy = 1'b0; e_pdxy = 1'b0; e_pen = 1'b0; e_ts = 1'b0;
    if (nph == "start") begin e_txy = 2'b11; e_tdxy = 2'b11; e_pxy = 1'b1; end
    else if (nph == "aim") e_ten = ~m_hit;
    else if (nph == "shoot") begin e_ten = ~m_hit; e_pen = 1'b1; e_pdxy = entered; end
    else if (nph == "reload") begin e_ten = ~m_hit; e_pxy = 1'b1; end
    else e_ts = entered;
    m_ph = nph;
  endtask

  function automatic logic [20:0] dut_vec();
    return {txy, tdxy, ten, pxy, pdxy, pen, ts, won, score, shots};
  endfunction

  function automatic logic [20:0] model_vec();
    return {e_txy, e_tdxy, e_ten, e_pxy, e_pdxy, e_pen, e_ts, m_won, m_score[7:0], m_shots[1:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    if (reset) m_reset();
    else m_step();
    #1;
    check(name, 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic set_in(input logic k, input logic [1:0] t, input logic p, input logic [1:0] c, input logic r);
    key = k; tws = t; pws = p; col = c; run = r;
  endtask

  typedef struct {
    logic        key;
    logic [1:0]  tws;
    logic        pws;
    logic [1:0]  col;
    logic        run;
    logic [20:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic k, input logic [1:0] t, input logic p, input logic [1:0] c,
                              input logic r, input logic [1:0] x_txy, input logic [1:0] x_tdxy,
                              input logic [1:0] x_ten, input logic x_pxy, input logic x_pdxy,
                              input logic x_pen, input logic x_ts, input logic x_won,
                              input logic [7:0] x_score, input logic [1:0] x_shots);
    vec_t v;
    v.key = k; v.tws = t; v.pws = p; v.col = c; v.run = r;
    v.exp = {x_txy, x_tdxy, x_ten, x_pxy, x_pdxy, x_pen, x_ts, x_won, x_score, x_shots};
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    // key tws pws col run | txy tdxy ten pxy pdxy pen ts won score shots
    vecs[0]  = mk(0, 2'b11, 1, 2'b00, 0, 2'b11, 2'b11, 2'b00, 1, 0, 0, 0, 0, 8'd0, 2'd3);
    vecs[1]  = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 8'd0, 2'd3);
    vecs[2]  = mk(1, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 1, 1, 0, 0, 8'd0, 2'd2);
    vecs[3]  = mk(1, 2'b11, 0, 2'b00, 0, 2'b00, 2'b00, 2'b11, 1, 0, 0, 0, 0, 8'd0, 2'd2);
    vecs[4]  = mk(1, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 8'd0, 2'd2);
    vecs[5]  = mk(1, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 8'd0, 2'd2);
    vecs[6]  = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 8'd0, 2'd2);
    vecs[7]  = mk(1, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 1, 1, 0, 0, 8'd0, 2'd1);
    vecs[8]  = mk(0, 2'b11, 1, 2'b01, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0, 0, 0, 8'd1, 2'd1);
    vecs[9]  = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0, 0, 8'd1, 2'd1);
    vecs[10] = mk(1, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0, 1, 1, 0, 0, 8'd1, 2'd0);
    vecs[11] = mk(0, 2'b11, 1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 8'd2, 2'd0);
    vecs[12] = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 1, 8'd2, 2'd0);
    vecs[13] = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'd2, 2'd0);
    vecs[14] = mk(0, 2'b11, 1, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 8'd2, 2'd0);
    vecs[15] = mk(0, 2'b11, 1, 2'b00, 0, 2'b11, 2'b11, 2'b00, 1, 0, 0, 0, 0, 8'd2, 2'd3);
    vecs[16] = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0, 8'd2, 2'd3);

    m_reset();
    tick("reset_hold");
    tick("reset_hold");
    @(negedge clk);
    reset = 1'b0;

    // Directed table from reset: first round, miss, held key, partial hit, win, END, restart
    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].key, vecs[i].tws, vecs[i].pws, vecs[i].col, vecs[i].run);
      tick($sformatf("model_tbl%0d", i));
      check($sformatf("tbl%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // Both targets hit by one torpedo
    set_in(1, 2'b11, 1, 2'b00, 0); tick("t4_fire");
    set_in(0, 2'b11, 1, 2'b11, 0); tick("t4_double_hit");
    check("t4_score", 32'(score), 32'd4);
    set_in(0, 2'b11, 1, 2'b00, 0); tick("t4_end");
    check("t4_won", 32'({won, ts}), 32'b11);
    tick("t4_end_hold");
    tick("t4_start");
    tick("t4_aim");

    // Three misses lose the round; timer holds END
    for (int s = 0; s < 3; s++) begin
      set_in(1, 2'b11, 1, 2'b00, 0); tick("t5_fire");
      set_in(0, 2'b11, 0, 2'b00, 0); tick("t5_miss");
      set_in(0, 2'b11, 1, 2'b00, 0); tick("t5_next");
    end
    check("t5_lost", 32'({won, ts, shots}), 32'b0100);
    set_in(0, 2'b11, 1, 2'b00, 1);
    for (int c = 0; c < 5; c++) begin
      tick("t5_end_held");
      check("t5_end_quiet", 32'({txy, pxy, ts}), 32'd0);
    end
    set_in(0, 2'b11, 1, 2'b00, 0); tick("t5_release");
    check("t5_start", 32'({txy, shots}), 32'b1111);
    tick("t5_aim");

    // Live target leaves the screen in AIM; then async reset in SHOOT
    set_in(0, 2'b01, 1, 2'b00, 0); tick("t6_offscreen");
    check("t6_lost_pulse", 32'({ts, won}), 32'b10);
    set_in(0, 2'b11, 1, 2'b00, 0);
    tick("t6_end"); tick("t6_start"); tick("t6_aim");
    set_in(1, 2'b11, 1, 2'b00, 0); tick("t6_shoot");
    check("t6_in_shoot", 32'({pen, pdxy}), 32'b11);
    #2 reset = 1'b1;
    key = 1'b0;
    #1;
    m_reset();
    check("t6_async_reset", 32'(dut_vec()), 32'd0);
    tick("t6_reset_hold");
    @(negedge clk);
    reset = 1'b0;
    tick("t6_restart");
    check("t6_restart_start", 32'({txy, pxy, shots}), 32'b11111);

    // Long random run against the model; drives score into saturation
    for (int n = 0; n < 6000; n++) begin
      key = 1'($urandom_range(0, 1));
      tws = 2'b11;
      for (int b = 0; b < 2; b++) if ($urandom_range(0, 39) == 0) tws[b] = 1'b0;
      pws = ($urandom_range(0, 3) != 0);
      col = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      run = 1'($urandom_range(0, 1));
      tick("rand");
    end
    check("score_saturated", 32'(score), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
